// File: rtl/pid_pwm_out.sv
// PWM output stage for a PID loop: latches |uk0| once per period, clamps it and drives a registered PWM/dir pair.
// Optional reversal dead time is compiled in with the macro PID_PWM_DEADTIME_EN.
module pid_pwm_out #(
    parameter int PERIOD   = 1000,
    parameter int DUTY_MAX = 1000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] uk0,
    output logic        pwm,
    output logic        dir,
    output logic        sat,
    output logic        period_start
);

`ifdef PID_PWM_DEADTIME_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] DUTY_LIM = 16'(DUTY_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        sat_q, sat_d;
    logic        pwm_q, pwm_d;
    logic        ps_q, ps_d;

    logic [15:0] uk0_ext;
    logic [15:0] mag;
    logic        load;

    // Two's-complement magnitude in 16 bits so that -16384 maps to +16384.
    always_comb begin
        uk0_ext = {uk0[14], uk0};
        mag     = uk0[14] ? (~uk0_ext + 16'd1) : uk0_ext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        sat_d   = sat_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (en) begin
                    load = 1'b1;
                end
            end
            default: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_LAST) begin
                    load  = 1'b1;
                    cnt_d = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`ifdef PID_PWM_DEADTIME_EN
                    if (state_q == DEAD && cnt_d == DEAD_LAST) begin
                        state_d = RUN;
                    end
`endif
                end
            end
        endcase

        // uk0 is only ever sampled on the edge that starts a new period.
        if (load) begin
            duty_d  = (mag > DUTY_LIM) ? DUTY_LIM : mag;
            sat_d   = (mag > DUTY_LIM);
            dir_d   = uk0[14];
            state_d = RUN;
`ifdef PID_PWM_DEADTIME_EN
            if (uk0[14] != dir_q && duty_q != 16'd0) begin
                state_d = DEAD;
            end
`endif
        end

        // Outputs are precomputed from next state so they leave the chip straight from flops.
        pwm_d = (state_d == RUN) && (cnt_d < duty_d);
        ps_d  = (state_d != IDLE) && (cnt_d == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            duty_q  <= 16'd0;
            dir_q   <= 1'b0;
            sat_q   <= 1'b0;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm          = pwm_q;
    assign dir          = dir_q;
    assign sat          = sat_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Randomised self-checking bench for pid_pwm_out against a period-level behavioural model.
module tb_pid_pwm_out;
    localparam int PERIOD   = 1000;
    localparam int DUTY_MAX = 1000;
    localparam int DEAD_CYC = 16;
`ifdef PID_PWM_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
    localparam int DB      = DEAD_CYC;
`else
    localparam bit DEAD_EN = 1'b0;
    localparam int DB      = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [14:0] uk0 = 15'd500;
    logic        pwm, dir, sat, period_start;

    int checks   = 0;
    int failures = 0;

    pid_pwm_out #(.PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .DEAD_CYC(DEAD_CYC)) dut (
        .clk(clk), .rst(rst), .en(en), .uk0(uk0),
        .pwm(pwm), .dir(dir), .sat(sat), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: where in the period we are, what duty was latched, and how much is blanked.
    bit m_active = 1'b0;
    int m_cnt    = 0;
    int m_duty   = 0;
    bit m_dir    = 1'b0;
    bit m_sat    = 1'b0;
    int m_blank  = 0;

    task automatic model_step();
        int v;
        int mag;
        if (rst) begin
            m_active = 1'b0; m_cnt = 0; m_duty = 0; m_dir = 1'b0; m_sat = 1'b0; m_blank = 0;
        end else if (!en) begin
            m_active = 1'b0; m_cnt = 0;
        end else if (!m_active || m_cnt == PERIOD - 1) begin
            v   = int'($signed(uk0));
            mag = (v < 0) ? -v : v;
            m_blank  = (DEAD_EN && ((v < 0) != m_dir) && m_duty != 0) ? DEAD_CYC : 0;
            m_dir    = (v < 0);
            m_sat    = (mag > DUTY_MAX);
            m_duty   = (mag > DUTY_MAX) ? DUTY_MAX : mag;
            m_cnt    = 0;
            m_active = 1'b1;
        end else begin
            m_cnt++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        chk("model_pwm", int'(pwm), int'(m_active && m_cnt >= m_blank && m_cnt < m_duty));
        chk("model_dir", int'(dir), int'(m_dir));
        chk("model_sat", int'(sat), int'(m_sat));
        chk("model_ps",  int'(period_start), int'(m_active && m_cnt == 0));
    end

    // Samples one whole period (first sample is cnt=0) and checks its literal shape.
    task automatic run_period(input string nm, input int exp_h, input int exp_first,
                              input logic exp_d, input logic exp_s,
                              input int mid_idx, input logic [14:0] mid_val,
                              input logic [14:0] next_val);
        int   highs = 0;
        int   pss   = 0;
        int   first = -1;
        logic d0    = 1'b0;
        logic s0    = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (i == 0) begin d0 = dir; s0 = sat; end
            if (pwm && first < 0) first = i;
            highs += int'(pwm);
            pss   += int'(period_start);
            if (i == mid_idx) uk0 = mid_val;
            if (i == PERIOD - 1) uk0 = next_val;
        end
        chk({nm, "_highs"}, highs, exp_h);
        chk({nm, "_first"}, first, (exp_h > 0) ? exp_first : -1);
        chk({nm, "_ps"}, pss, 1);
        chk({nm, "_dir"}, int'(d0), int'(exp_d));
        chk({nm, "_sat"}, int'(s0), int'(exp_s));
        $display("period %s: highs=%0d first=%0d dir=%0b sat=%0b", nm, highs, first, d0, s0);
    endtask

    function automatic logic [14:0] pick_uk0();
        logic [14:0] v;
        case ($urandom_range(0, 5))
            0: v = 15'd0;
            1: v = 15'd1000;
            2: v = 15'd1001;
            3: v = 15'h4000;
            4: v = 15'($urandom);
            default: v = 15'($urandom_range(0, 2400) - 1200);
        endcase
        return v;
    endfunction

    initial begin
        int highs;
        // Reset held with en=1: every output stays low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pwm", int'(pwm), 0);
            chk("rst_dir", int'(dir), 0);
            chk("rst_sat", int'(sat), 0);
            chk("rst_ps",  int'(period_start), 0);
        end
        rst = 1'b0;
        uk0 = 15'd350;
        run_period("p350",    350,        0,  1'b0, 1'b0, -1,  15'd0,   -15'sd500);
        run_period("n500",    500 - DB,   DB, 1'b1, 1'b0, -1,  15'd0,   15'd5000);
        run_period("sat5000", 1000 - DB,  DB, 1'b0, 1'b1, -1,  15'd0,   15'h4000);
        run_period("m16384",  1000 - DB,  DB, 1'b1, 1'b1, -1,  15'd0,   15'd200);
        run_period("chg200",  200 - DB,   DB, 1'b0, 1'b0, 100, 15'd800, 15'd800);
        run_period("p800",    800,        0,  1'b0, 1'b0, -1,  15'd0,   15'd300);
        run_period("p300",    300,        0,  1'b0, 1'b0, -1,  15'd0,   -15'sd300);
        run_period("n300",    300 - DB,   DB, 1'b1, 1'b0, -1,  15'd0,   15'd350);

        // Drop en after the cnt=150 cycle of a 350 period.
        highs = 0;
        for (int i = 0; i <= 150; i++) begin
            @(negedge clk);
            highs += int'(pwm);
        end
        chk("endrop_highs", highs, 151 - DB);
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("endrop_pwm", int'(pwm), 0);
            chk("endrop_ps",  int'(period_start), 0);
            chk("endrop_dir", int'(dir), 0);
        end
        $display("en dropped at cnt=150: highs_before=%0d", highs);
        en = 1'b1;
        run_period("reen350", 350, 0, 1'b0, 1'b0, -1, 15'd0, pick_uk0());

        // Random traffic: uk0 changes, en toggles and occasional mid-period resets.
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if ($urandom_range(0, 199) == 0) uk0 = pick_uk0();
            if ($urandom_range(0, 2999) == 0) en = ~en;
            if ($urandom_range(0, 7999) == 0) rst = 1'b1;
            if (i % 5000 == 4999)
                $display("random segment %0d: uk0=%0d en=%0b", i / 5000, $signed(uk0), en);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
